// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC generator: issues in-order instruction fetches along the predicted path,
// buffers responses in a small queue and hands {pc, inst, predicted next pc} to decode.
// Optional simulation checks are compiled in when FETCH_CHECK_EN is defined.
module fetch_pc_gen #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int          QUEUE_DEPTH  = 4,
   parameter int          QUEUE_AW     = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] pred_pc,
   input  logic [31:0] pred_next_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_inst,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst,
   output logic [31:0] out_pred_next_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);

   localparam logic [QUEUE_AW+1:0] DEPTH_W = (QUEUE_AW+2)'(QUEUE_DEPTH);

   logic [31:0]         pc_reg;
   logic                run_reg;
   logic [QUEUE_AW-1:0] head_reg;
   logic [QUEUE_AW-1:0] tail_reg;
   logic [QUEUE_AW:0]   count_reg;
   logic [QUEUE_AW:0]   data_cnt_reg;
   logic [QUEUE_AW:0]   drop_cnt_reg;

   logic                has_data_reg [QUEUE_DEPTH];
   logic [31:0]         ent_pc_mem   [QUEUE_DEPTH];
   logic [31:0]         ent_pred_mem [QUEUE_DEPTH];
   logic [31:0]         ent_inst_mem [QUEUE_DEPTH];

   logic [QUEUE_AW+1:0] occupancy;
   logic [QUEUE_AW:0]   pending;
   logic [QUEUE_AW-1:0] fill_idx;
   logic                accept;
   logic                consume;
   logic                resp_fill;
   logic                resp_drop;

   // Responses arrive in order, so entries holding data always form a prefix starting at head.
   always_comb begin
      occupancy = {1'b0, count_reg} + {1'b0, drop_cnt_reg};
      pending   = count_reg - data_cnt_reg;
      fill_idx  = head_reg + data_cnt_reg[QUEUE_AW-1:0];
      accept    = imem_req_valid && imem_req_ready;
      consume   = out_valid && out_ready;
      resp_drop = imem_resp_valid && (drop_cnt_reg != '0);
      resp_fill = imem_resp_valid && (drop_cnt_reg == '0) && !redirect_valid;
   end

   // run_reg keeps the request port quiet during reset without a combinational rst_n path.
   assign imem_req_valid   = run_reg && (occupancy < DEPTH_W);
   assign imem_req_addr    = pc_reg;
   assign pred_pc          = pc_reg;
   assign out_valid        = has_data_reg[head_reg];
   assign out_pc           = ent_pc_mem[head_reg];
   assign out_inst         = ent_inst_mem[head_reg];
   assign out_pred_next_pc = ent_pred_mem[head_reg];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_reg       <= RESET_VECTOR;
         run_reg      <= 1'b0;
         head_reg     <= '0;
         tail_reg     <= '0;
         count_reg    <= '0;
         data_cnt_reg <= '0;
         drop_cnt_reg <= '0;
      end else begin
         run_reg <= 1'b1;
         if (redirect_valid) begin
            // Unfilled entries plus a request accepted now all have responses still to discard.
            pc_reg       <= redirect_pc;
            head_reg     <= tail_reg;
            count_reg    <= '0;
            data_cnt_reg <= '0;
            drop_cnt_reg <= drop_cnt_reg + pending + (QUEUE_AW+1)'(accept)
                            - (QUEUE_AW+1)'(imem_resp_valid);
         end else begin
            if (accept) begin
               pc_reg   <= pred_next_pc;
               tail_reg <= tail_reg + 1'b1;
            end
            if (consume)
               head_reg <= head_reg + 1'b1;
            count_reg    <= count_reg + (QUEUE_AW+1)'(accept) - (QUEUE_AW+1)'(consume);
            data_cnt_reg <= data_cnt_reg + (QUEUE_AW+1)'(resp_fill) - (QUEUE_AW+1)'(consume);
            drop_cnt_reg <= drop_cnt_reg - (QUEUE_AW+1)'(resp_drop);
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               has_data_reg[gi] <= 1'b0;
            else if (redirect_valid)
               has_data_reg[gi] <= 1'b0;
            else if (resp_fill && fill_idx == QUEUE_AW'(gi))
               has_data_reg[gi] <= 1'b1;
            else if ((consume && head_reg == QUEUE_AW'(gi)) ||
                     (accept && tail_reg == QUEUE_AW'(gi)))
               has_data_reg[gi] <= 1'b0;
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (accept && !redirect_valid) begin
         ent_pc_mem[tail_reg]   <= pc_reg;
         ent_pred_mem[tail_reg] <= pred_next_pc;
      end
      if (resp_fill)
         ent_inst_mem[fill_idx] <= imem_resp_inst;
   end

`ifdef FETCH_CHECK_EN
   logic [31:0] prev_addr_reg;
   logic        prev_stall_reg;

   always @(posedge clk) begin
      prev_addr_reg  <= imem_req_addr;
      prev_stall_reg <= rst_n && imem_req_valid && !imem_req_ready && !redirect_valid;
      if (rst_n) begin
         if (imem_resp_valid && ({1'b0, pending} + {1'b0, drop_cnt_reg}) == '0)
            $error("fetch_pc_gen: response with nothing outstanding, pc=%h", pc_reg);
         if (prev_stall_reg && (!imem_req_valid || imem_req_addr != prev_addr_reg))
            $error("fetch_pc_gen: request changed while stalled, pc=%h", pc_reg);
         if (occupancy > DEPTH_W)
            $error("fetch_pc_gen: queue overcommitted, pc=%h", pc_reg);
         if (redirect_valid && redirect_pc[1:0] != 2'b00)
            $error("fetch_pc_gen: misaligned redirect, pc=%h", pc_reg);
      end
   end
`else
   // Checks compiled out; datapath is identical either way.
`endif

endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
Fetch-stage PC generator directly upstream of the two-bit-counter branch predictor.
- Holds the architectural fetch PC and presents it to the predictor.
- Uses the predicted next address to issue in-order instruction-memory requests.
- Tracks in-flight requests in a small queue and delivers {pc, inst, predicted next pc} to decode with a valid/ready handshake.
- Handles execute-stage redirects, including discarding responses still in flight.

Parameters:
RESET_VECTOR, 32'h0000_0000, first fetch address after reset
QUEUE_DEPTH, 4, max requests issued-but-not-consumed (in flight + buffered), power of two
QUEUE_AW, 2, log2(QUEUE_DEPTH)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
pred_pc  out  32  current fetch PC to predictor (= pc register)
pred_next_pc  in  32  predictor result for pred_pc, combinational same cycle
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  fetch address (= pc register)
imem_resp_valid  in  1  one response per accepted request, in order, no backpressure
imem_resp_inst  in  32  instruction word
out_valid  out  1  head entry holds an instruction
out_ready  in  1  decode accepts
out_pc  out  32  head entry pc
out_inst  out  32  head entry instruction
out_pred_next_pc  out  32  head entry predicted next pc
redirect_valid  in  1  misprediction / trap redirect from execute
redirect_pc  in  32  corrected fetch address

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_VECTOR; queue empty (head=tail=0, count=0); drop_cnt=0.
  - out_valid=0, imem_req_valid=0 while rst_n low.
  - First cycle after release: imem_req_valid=1, addr=RESET_VECTOR.
- Queue entry: {pc, pred_next, inst, has_data}.
- count = allocated entries; drop_cnt = responses to discard.
- Request issue:
  - imem_req_valid = (count + drop_cnt < QUEUE_DEPTH). Widths are QUEUE_AW+1 bits.
  - Accept (valid & ready): allocate tail with {pc, pred_next_pc, has_data=0}; pc <= pred_next_pc.
  - Addr/valid must stay stable until accepted, unless a redirect occurs.
- Response:
  - If drop_cnt>0: decrement drop_cnt, data discarded.
  - Otherwise: write inst into the oldest entry with has_data=0 and set has_data.
  - An entry's response never arrives in the same cycle as its request accept (memory latency ≥1).
- Output:
  - out_valid = entry[head].has_data; outputs are entry[head] fields.
  - Handshake (valid & ready): head++, count--.
  - Back-to-back: one instruction per cycle sustained when memory latency ≤ QUEUE_DEPTH-1.
- Redirect (priority over everything that cycle except an output handshake already completing):
  - pc <= redirect_pc.
  - Every entry not consumed this cycle is freed: count <= 0, head <= tail.
  - drop_cnt_next = drop_cnt + (entries with has_data=0) + (req accept this cycle) − (imem_resp_valid this cycle).
  - A request accepted in the redirect cycle is counted as dropped, not queued.
  - Next cycle: imem_req_valid obeys the normal rule, addr = redirect_pc.
- Wrap-around: head/tail are QUEUE_AW bits, wrap modulo QUEUE_DEPTH.
  - Full: count + drop_cnt == QUEUE_DEPTH → imem_req_valid=0.
  - Empty: count==0 → out_valid=0.
- No combinational path from out_ready or redirect_valid to imem_req_valid.
- The only input→output combinational path is pred_next_pc (feeds the registered pc only, not outputs).

Optional Feature:
FETCH_CHECK_EN
- Defined: simulation-only checks, each reporting via $error with the cycle's pc:
  - imem_resp_valid with count−(entries with data)+drop_cnt==0;
  - imem_req_addr/valid changing while valid & !ready without redirect;
  - count+drop_cnt > QUEUE_DEPTH;
  - redirect_pc[1:0] != 0.
- Undefined: no checks, identical RTL behaviour.

Test Plan:
- Reset release, predictor returns pc+4, memory latency 1, out_ready=1 → requests 0x0,0x4,0x8,…; out_pc 0x0,0x4,0x8 one per cycle starting cycle 2 after release; out_pred_next_pc=out_pc+4.
- Predictor returns 0x100 for pc 0x8 → next request addr 0x100; out entry pc=0x8 has out_pred_next_pc=0x100.
- out_ready=0 held, latency 1 → exactly 4 requests accepted (0x0–0xC), then imem_req_valid=0; raising out_ready drains 4 entries in order, then issue resumes at 0x10.
- Latency 3, two requests outstanding, redirect to 0x200 → drop_cnt=2; next two responses produce no out_valid; first delivered out_pc=0x200.
- Redirect in same cycle as request accept at 0x8 and response for 0x4 → 0x4 response discarded, 0x8 counted in drop_cnt, next request addr=0x200.
- rst_n asserted mid-stream with 3 entries and 2 in flight → out_valid=0 and imem_req_valid=0 immediately; after release fetch restarts at RESET_VECTOR with drop_cnt=0.
